// File: rtl/alu_pkg.sv
// Shared ALU op-select codes and mod/div sequencer state encoding.
// Imported by the sequencer and by anything wiring it to the ALU.
package alu_pkg;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_ROL = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NEG_XOR = 3'd1,
    NEG_INC = 3'd2,
    SUB     = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_mod_sequencer.sv
// Multi-cycle unsigned A mod B / A div B controller driving an external ALU.
// Ports: clk/rst, start/op_a/op_b in, busy/done/result/quotient/err out, alu_* ALU link.
module alu_mod_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] quotient,
  output logic             err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c0,
  input  logic             alu_z
);

  localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] negb_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (op_b == '0) ? DONE : NEG_XOR;
      end
      NEG_XOR: state_d = NEG_INC;
      NEG_INC: state_d = SUB;
      // A carry with a zero sum means the remainder just hit 0 exactly.
      SUB: begin
        if (!alu_c0 || alu_z)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = ALU_AND;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: ;
      NEG_XOR: begin
        alu_a   = b_q;
        alu_b   = '1;
        alu_sel = ALU_XOR;
        busy    = 1'b1;
      end
      NEG_INC: begin
        alu_a   = negb_q;
        alu_b   = W_ONE;
        alu_sel = ALU_ADD;
        busy    = 1'b1;
      end
      SUB: begin
        alu_a   = rem_q;
        alu_b   = negb_q;
        alu_sel = ALU_ADD;
        busy    = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      b_q    <= '0;
      negb_q <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rem_q <= op_a;
            b_q   <= op_b;
            quo_q <= '0;
            err_q <= (op_b == '0);
          end
        end
        NEG_XOR: negb_q <= alu_out;
        NEG_INC: negb_q <= alu_out;
        // Carry out of rem + (-B) means no borrow: rem >= B.
        SUB: begin
          if (alu_c0) begin
            rem_q <= alu_out;
            quo_q <= quo_q + W_ONE;
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

  assign result   = rem_q;
  assign quotient = quo_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_mod_sequencer.sv
// Bench for alu_mod_sequencer with a behavioural ALU and a result scoreboard.
// Covers directed cases, mid-run start/reset, back-to-back and random ops.
module tb_alu_mod_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] quotient;
  logic       err;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_c0;
  logic       alu_z;

  int nchk = 0;
  int errs = 0;

  typedef struct {
    logic [7:0] rem;
    logic [7:0] quo;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_mod_sequencer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .quotient (quotient),
    .err      (err),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_c0   (alu_c0),
    .alu_z    (alu_z)
  );

  always_comb begin
    alu_out = '0;
    alu_c0  = 1'b0;
    case (alu_sel)
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      ALU_ADD: {alu_c0, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      default: alu_out = {alu_a[6:0], alu_a[7]};
    endcase
  end
  assign alu_z = (alu_out == 8'h00);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   q;
    int   r;
    if (b == 8'd0) begin
      e.rem = a;
      e.quo = 8'd0;
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      q     = int'(a) / int'(b);
      r     = int'(a) % int'(b);
      e.rem = r[7:0];
      e.quo = q[7:0];
      e.err = 1'b0;
      if (a < b)       e.lat = 3 + 1;
      else if (r == 0) e.lat = 3 + q;
      else             e.lat = 3 + q + 1;
    end
    return e;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the IDLE
  // cycle after done, so consecutive calls run back-to-back.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   cyc;
    bit   seen;
    bit   busy_ok;
    bit   sel_ok;
    bit   neg_ok;
    sb.push_back(model(a, b));
    sel_ok = (alu_sel == ALU_AND);
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    op_a    = 8'($urandom);
    op_b    = 8'($urandom);
    cyc     = 1;
    seen    = 0;
    busy_ok = 1;
    neg_ok  = 1;
    while (!seen && cyc < 400) begin
      if (!busy) busy_ok = 0;
      if (alu_sel != ALU_AND) sel_ok = 0;
      if (cyc == 1 && b != 8'd0)
        neg_ok = (alu_sel == ALU_XOR) && (alu_a == b) && (alu_b == 8'hFF);
      if (done) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    e = sb.pop_front();
    chk("latency", cyc, e.lat);
    chk("result", 32'(result), 32'(e.rem));
    chk("quotient", 32'(quotient), 32'(e.quo));
    chk("err", 32'(err), 32'(e.err));
    chk("busy_held", 32'(busy_ok), 32'd1);
    if (b == 8'd0) chk("alu_idle", 32'(sel_ok), 32'd1);
    else           chk("neg_xor_drive", 32'(neg_ok), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("result_hold", 32'(result), 32'(e.rem));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_quot", 32'(quotient), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sel", 32'(alu_sel), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd7, 8'd3);
    run_op(8'd9, 8'd3);
    run_op(8'd2, 8'd200);
    run_op(8'd5, 8'd0);
    run_op(8'd255, 8'd1);
    run_op(8'd0, 8'd5);

    // 200 mod 7 interrupted: stray start mid-SUB, then reset.
    start = 1'b1;
    op_a  = 8'd200;
    op_b  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_quot", 32'(quotient), 32'd7);
    chk("mid_rem", 32'(result), 32'd151);
    start = 1'b1;
    op_a  = 8'd9;
    op_b  = 8'd3;
    @(negedge clk);
    start = 1'b0;
    chk("ign_quot", 32'(quotient), 32'd8);
    chk("ign_rem", 32'(result), 32'd144);
    chk("ign_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_quot", 32'(quotient), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_alu", 32'({alu_a, alu_b, 6'd0, alu_sel}), 32'd0);
    rst = 1'b0;
    run_op(8'd200, 8'd7);

    for (int i = 0; i < 8; i++)
      run_op(8'($urandom), 8'($urandom_range(0, 40)));

    $display("Simulation finished: %0d checks, %0d errors", nchk, errs);
    $finish;
  end

endmodule
